// File: rtl/ops_result_checker_if.sv
// Handshake and result bundle between a result source and ops_result_checker.
interface ops_result_checker_if #(
  parameter int RES_W = 64,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] spec_res;
  logic [RES_W-1:0] impl_res;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic [RES_W-1:0] first_err_diff;

  modport master (
    output start, num_vectors, in_valid, spec_res, impl_res,
    input  in_ready, busy, done, pass, vec_cnt, err_cnt, first_err_idx, first_err_diff
  );

  modport slave (
    input  start, num_vectors, in_valid, spec_res, impl_res,
    output in_ready, busy, done, pass, vec_cnt, err_cnt, first_err_idx, first_err_diff
  );
endinterface

// File: rtl/ops_result_checker.sv
// Compares reference vs implementation result pairs over a run of num_vectors pairs.
// Optional macro OPS_CHECKER_STOP_ON_ERR_EN: end the run on the first mismatching pair.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting result pairs
// DONE  | run finished, results held until start or rst
module ops_result_checker #(
  parameter int RES_W = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  ops_result_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [RES_W-1:0] first_diff_q, first_diff_d;

  logic [RES_W-1:0] diff;
  logic             mismatch;
  logic [CNT_W-1:0] vec_inc;

  // Case-inequality per bit so X/Z differences are flagged as 1.
  always_comb begin
    diff = '0;
    for (int i = 0; i < RES_W; i++) begin
      diff[i] = (bus.spec_res[i] !== bus.impl_res[i]);
    end
  end

  assign mismatch = |diff;
  assign vec_inc  = vec_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    vec_cnt_d    = vec_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_diff_d = first_diff_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          num_d        = bus.num_vectors;
          vec_cnt_d    = '0;
          err_cnt_d    = '0;
          first_idx_d  = '0;
          first_diff_d = '0;
          state_d      = (bus.num_vectors != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          vec_cnt_d = vec_inc;
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            // err_cnt never returns to zero within a run, so zero marks "no mismatch yet".
            if (err_cnt_q == '0) begin
              first_idx_d  = vec_cnt_q;
              first_diff_d = diff;
            end
          end
          if (vec_inc == num_q) state_d = DONE;
`ifdef OPS_CHECKER_STOP_ON_ERR_EN
          if (mismatch) state_d = DONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      num_q        <= '0;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_diff_q <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      vec_cnt_q    <= vec_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_diff_q <= first_diff_d;
    end
  end

  assign bus.in_ready       = (state_q == RUN);
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = (state_q == DONE) && (err_cnt_q == '0);
  assign bus.vec_cnt        = vec_cnt_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.first_err_idx  = first_idx_q;
  assign bus.first_err_diff = first_diff_q;

endmodule

// File: tb/tb_ops_result_checker.sv
// Randomized and directed bench for ops_result_checker against a run-level reference model.
module tb_ops_result_checker;
  localparam int RES_W = 64;
  localparam int CNT_W = 16;
  localparam int MAXV  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ops_result_checker_if #(.RES_W(RES_W), .CNT_W(CNT_W)) bus ();
  ops_result_checker #(.RES_W(RES_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [RES_W-1:0] spec_a [MAXV];
  logic [RES_W-1:0] impl_a [MAXV];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RES_W-1:0] bitdiff(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
    logic [RES_W-1:0] r;
    for (int i = 0; i < RES_W; i++) r[i] = (a[i] !== b[i]);
    return r;
  endfunction

  function automatic void fill_random(input int n, input int err_pct);
    for (int i = 0; i < n; i++) begin
      spec_a[i] = {$urandom, $urandom};
      impl_a[i] = spec_a[i];
      if ($urandom_range(0, 99) < err_pct)
        impl_a[i] = spec_a[i] ^ (64'd1 << $urandom_range(0, RES_W - 1));
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_vec"}, bus.vec_cnt, 0);
    check({tag, "_err"}, bus.err_cnt, 0);
    check({tag, "_idx"}, bus.first_err_idx, 0);
    check({tag, "_diff"}, bus.first_err_diff, 0);
  endtask

  // gap: 0 = valid every cycle, 1 = valid toggles, 2 = random valid
  task automatic do_run(input string tag, input int n, input int gap);
    int exp_n, exp_err, exp_idx, k, cyc;
    logic [RES_W-1:0] exp_diff, d;
    bit v;
    exp_n = n; exp_err = 0; exp_idx = 0; exp_diff = '0;
    for (int i = 0; i < n; i++) begin
      d = bitdiff(spec_a[i], impl_a[i]);
      if (d != '0) begin
        if (exp_err == 0) begin
          exp_idx  = i;
          exp_diff = d;
        end
        exp_err++;
`ifdef OPS_CHECKER_STOP_ON_ERR_EN
        exp_n = i + 1;
        break;
`endif
      end
    end

    bus.start = 1'b1;
    bus.num_vectors = CNT_W'(n);
    step();
    bus.start = 1'b0;
    if (n == 0) begin
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_pass"}, bus.pass, 1);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_vec"}, bus.vec_cnt, 0);
      step();
      check({tag, "_in_ready2"}, bus.in_ready, 0);
      return;
    end
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_vec0"}, bus.vec_cnt, 0);
    check({tag, "_err0"}, bus.err_cnt, 0);

    k = 0;
    cyc = 0;
    while (k < exp_n && cyc < 200) begin
      v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.spec_res = spec_a[k];
      bus.impl_res = impl_a[k];
      if (k > 0 && bus.in_ready !== 1'b1) check({tag, "_ready_mid"}, bus.in_ready, 1);
      step();
      if (v) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (k < exp_n) check({tag, "_timeout"}, k, exp_n);

    check({tag, "_done"}, bus.done, 1);
    check({tag, "_busy_end"}, bus.busy, 0);
    check({tag, "_vec"}, bus.vec_cnt, exp_n);
    check({tag, "_err"}, bus.err_cnt, exp_err);
    check({tag, "_idx"}, bus.first_err_idx, exp_idx);
    check({tag, "_diff"}, bus.first_err_diff, exp_diff);
    check({tag, "_pass"}, bus.pass, exp_err == 0);

    // Traffic while DONE must not count.
    bus.in_valid = 1'b1;
    bus.spec_res = '0;
    bus.impl_res = '1;
    check({tag, "_ready_done"}, bus.in_ready, 0);
    step();
    step();
    bus.in_valid = 1'b0;
    check({tag, "_vec_hold"}, bus.vec_cnt, exp_n);
    check({tag, "_err_hold"}, bus.err_cnt, exp_err);
    check({tag, "_done_hold"}, bus.done, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_vectors = '0;
    bus.in_valid = 1'b0;
    bus.spec_res = '0;
    bus.impl_res = '0;
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Four equal pairs back to back.
    fill_random(4, 0);
    do_run("equal4", 4, 0);

    // Five pairs, mismatches at 2 and 4.
    fill_random(5, 0);
    impl_a[2] = spec_a[2] ^ 64'h5;
    impl_a[4] = spec_a[4] ^ 64'h8000_0000_0000_0000;
    do_run("err5", 5, 0);

    fill_random(3, 0);
    do_run("toggle3", 3, 1);

    do_run("zero", 0, 0);

    // Reset mid-run after two accepts.
    fill_random(4, 0);
    bus.start = 1'b1;
    bus.num_vectors = 16'd4;
    step();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.spec_res = spec_a[0];
    bus.impl_res = spec_a[0] ^ 64'h1;
    step();
    step();
    bus.in_valid = 1'b0;
    check("midrst_vec2", bus.vec_cnt, 2);
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    check_all_zero("midrst");
    fill_random(1, 0);
    do_run("after_rst", 1, 0);

    // X on implementation bit 0.
    fill_random(2, 0);
    spec_a[0][0] = 1'b0;
    impl_a[0] = spec_a[0];
    impl_a[0][0] = 1'bx;
    do_run("xbit", 2, 0);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, MAXV);
      fill_random(n, 25);
      do_run($sformatf("rand%0d", r), n, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ops_result_checker.md
OPS_RESULT_CHECKER -- requirements
Module: ops_result_checker

Interface
REQ-001: Parameter RES_W, default 64: width of the concatenated operator-result vector.
REQ-002: Parameter CNT_W, default 16: width of the vector and error counters.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: start  input  1  begin a check run; sampled in IDLE or DONE only.
REQ-006: num_vectors  input  CNT_W  vectors expected in the run; sampled when start is accepted.
REQ-007: in_valid  input  1  spec_res/impl_res hold a result pair.
REQ-008: in_ready  output  1  checker accepts a result pair this cycle.
REQ-009: spec_res  input  RES_W  reference-model result vector.
REQ-010: impl_res  input  RES_W  implementation result vector.
REQ-011: busy  output  1  run in progress (state RUN).
REQ-012: done  output  1  run finished (state DONE).
REQ-013: pass  output  1  done and err_cnt == 0.
REQ-014: vec_cnt  output  CNT_W  result pairs accepted this run.
REQ-015: err_cnt  output  CNT_W  mismatching pairs this run; saturates at all-ones.
REQ-016: first_err_idx  output  CNT_W  vec_cnt value of the first mismatching pair.
REQ-017: first_err_diff  output  RES_W  spec_res XOR impl_res of the first mismatch, with differing X/Z bits as 1.

Function
REQ-018: FSM states: IDLE, RUN, DONE.
REQ-019: IDLE or DONE with start=1 and num_vectors!=0: clear vec_cnt, err_cnt, first_err_idx, first_err_diff; latch num_vectors; go to RUN.
REQ-020: IDLE or DONE with start=1 and num_vectors==0: clear counters and capture registers; go to DONE (pass=1).
REQ-021: in_ready = 1 only in RUN, combinationally from state; pair accepted on in_valid && in_ready.
REQ-022: Accepted pair mismatches when spec_res and impl_res differ under case-inequality (differing X/Z bits count).
REQ-023: On accept: vec_cnt += 1; on mismatch, err_cnt += 1 unless already all-ones.
REQ-024: On the first mismatch of a run only: first_err_idx <= pre-increment vec_cnt; first_err_diff <= per-bit diff.
REQ-025: RUN to DONE on the accept that makes vec_cnt equal latched num_vectors; done asserts the next cycle.
REQ-026: start in RUN is ignored; in_valid outside RUN is ignored and counts nothing.
REQ-027: Outputs are registered except in_ready, busy, done, pass, which decode state and err_cnt.
REQ-028: DONE holds all counters and capture registers stable until start or rst.

Reset
REQ-029: rst=1 forces IDLE; vec_cnt, err_cnt, first_err_idx, first_err_diff = 0; in_ready, busy, done, pass = 0.
REQ-030: rst mid-RUN abandons the run with no partial result retained; rst takes priority over start and accept in the same cycle.

Configuration
REQ-031: Macro OPS_CHECKER_STOP_ON_ERR_EN defined: the first mismatching accept moves RUN to DONE immediately (pass=0, err_cnt=1, vec_cnt includes that pair).
REQ-032: Macro OPS_CHECKER_STOP_ON_ERR_EN undefined: the run always continues until num_vectors pairs are accepted.

Verification
REQ-033: rst, start with num_vectors=4, 4 equal pairs with in_valid=1 every cycle -> done 1 cycle after 4th accept, vec_cnt=4, err_cnt=0, pass=1.
REQ-034: num_vectors=5, pairs 2 and 4 differ (pair 2 diff=0x...0005) -> err_cnt=2, first_err_idx=2, first_err_diff=0x5, pass=0; with STOP_ON_ERR_EN: done after 3 accepts, vec_cnt=3, err_cnt=1.
REQ-035: in_valid toggling 1/0 each cycle, num_vectors=3 -> only valid cycles counted; done after 3rd accept; in_valid while DONE leaves vec_cnt=3.
REQ-036: start with num_vectors=0 -> DONE next cycle, pass=1, in_ready never asserts.
REQ-037: rst asserted after 2 of 4 accepts -> IDLE, all outputs 0; new start with num_vectors=1 and 1 equal pair -> pass=1, vec_cnt=1.
REQ-038: impl_res bit 0 = X, spec_res bit 0 = 0 -> counted as mismatch, first_err_diff bit 0 = 1.
